// File: rtl/adc_txemu_pkg.sv
// Shared constants and helpers for the ADC transmit emulator: word geometry,
// pattern-generator mode codes, frame shape and the PRBS feedback polynomial.
package adc_txemu_pkg;

  localparam int NBITS     = 12;
  localparam int LANE_BITS = 6;

  typedef enum logic [3:0] {
    MODE_EXT    = 4'd0,
    MODE_FIXED  = 4'd1,
    MODE_RAMP   = 4'd2,
    MODE_ALT    = 4'd3,
    MODE_DESKEW = 4'd4,
    MODE_PRBS   = 4'd5
  } mode_e;

  // Frame bits in transmit order r0 f0 r1 f1 r2 f2.
  localparam logic [5:0]       FRAME_PAT = 6'b111000;
  localparam logic [NBITS-1:0] PAT_AAA   = 12'hAAA;
  localparam logic [NBITS-1:0] PAT_555   = 12'h555;
  localparam logic [NBITS-1:0] PAT_FC0   = 12'hFC0;

  // Fibonacci LFSR for x^12 + x^11 + x^10 + x^4 + 1.
  function automatic logic [NBITS-1:0] lfsr_next(input logic [NBITS-1:0] q);
    return {q[10:0], q[11] ^ q[10] ^ q[9] ^ q[3]};
  endfunction

  function automatic logic [2:0] slip_clamp(input logic [2:0] s);
    return (s > 3'd5) ? 3'd5 : s;
  endfunction

endpackage

// File: rtl/adc_txemu_adc1xmt.sv
// One channel's two-lane serializer: picks the current bit pair of each 6-bit lane
// (MSB first) and delays each lane's bit stream by 0..5 bits through a short history.
module adc_txemu_adc1xmt
  import adc_txemu_pkg::*;
(
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             emit,
  input  logic [1:0]       pair_sel,
  input  logic [NBITS-1:0] word,
  input  logic [2:0]       slip,
  output logic [1:0]       dout_r,
  output logic [1:0]       dout_f
);

  logic [1:0][4:0] hist_p1;
  logic [1:0][6:0] seq_p0;
  logic [1:0][1:0] pair_p0;

  always_comb begin
    pair_p0 = '0;
    seq_p0  = '0;
    for (int l = 0; l < 2; l++) begin
      case (pair_sel)
        2'd0:    pair_p0[l] = word[l*LANE_BITS+4 +: 2];
        2'd1:    pair_p0[l] = word[l*LANE_BITS+2 +: 2];
        default: pair_p0[l] = word[l*LANE_BITS   +: 2];
      endcase
      if (!emit) pair_p0[l] = 2'b00;
      // seq bit k is the lane bit sent k bit-times before the current falling bit.
      seq_p0[l] = {hist_p1[l], pair_p0[l]};
    end
  end

  // ---- stage p1: history and registered lane outputs ----
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      hist_p1 <= '0;
      dout_r  <= '0;
      dout_f  <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        hist_p1[l] <= seq_p0[l][4:0];
        dout_r[l]  <= seq_p0[l][slip + 3'd1];
        dout_f[l]  <= seq_p0[l][slip];
      end
    end
  end

endmodule

// File: rtl/adc_txemu.sv
// Transmit-side emulator for a 4-channel, 12-bit, two-lane DDR ADC: builds sample words
// from external data or test patterns and serializes them into bit pairs plus frame.
module adc_txemu
  import adc_txemu_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter logic [11:0] PRBS_SEED = 12'hFFF
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 enb,
  input  logic [3:0]           mode,
  input  logic [11:0]          pattern,
  input  logic [2:0]           slip,
  input  logic [NCH*NBITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [2*NCH-1:0]     dout_r,
  output logic [2*NCH-1:0]     dout_f,
  output logic                 fr_r,
  output logic                 fr_f,
  output logic [15:0]          undr_cnt,
  input  logic                 cnt_clr
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  mode_e                mode_sel;
  logic [1:0]           phase_p0;
  logic [NCH*NBITS-1:0] word_p0;
  logic                 vld_p0;
  logic [NBITS-1:0]     ramp_p0;
  logic [NBITS-1:0]     lfsr_p0;
  logic                 alt_p0;
  logic [2:0]           slip_p0;
  logic [15:0]          undr_cnt_p0;
  logic                 load;
  logic                 underrun;
  logic                 emit;
  logic [1:0]           pair_sel;
  logic [1:0]           frame_pair;
  logic [NCH*NBITS-1:0] next_word;

  assign mode_sel  = mode_e'(mode);
  assign load      = enb && (phase_p0 == 2'd0);
  assign din_ready = load && (mode_sel == MODE_EXT);
  assign underrun  = din_ready && !din_valid;
  assign undr_cnt  = undr_cnt_p0;
  // Output lags the word register by one edge, so phase 1 emits pair 0.
  assign pair_sel  = (phase_p0 == 2'd0) ? 2'd2 : phase_p0 - 2'd1;
  assign emit      = enb && vld_p0;

  always_comb begin
    next_word = '0;
    case (mode_sel)
      MODE_EXT:    next_word = din_valid ? din : word_p0;
      MODE_FIXED:  next_word = {NCH{pattern}};
      MODE_RAMP:   for (int k = 0; k < NCH; k++) next_word[k*NBITS +: NBITS] = ramp_p0 + NBITS'(k);
      MODE_ALT:    next_word = {NCH{alt_p0 ? PAT_555 : PAT_AAA}};
      MODE_DESKEW: next_word = {NCH{PAT_FC0}};
      MODE_PRBS:   next_word = {NCH{lfsr_p0}};
      default:     next_word = '0;
    endcase
  end

  always_comb begin
    case (pair_sel)
      2'd0:    frame_pair = FRAME_PAT[5:4];
      2'd1:    frame_pair = FRAME_PAT[3:2];
      default: frame_pair = FRAME_PAT[1:0];
    endcase
  end

  // ---- stage p0: phase, word load, generators, underrun counter, frame ----
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      phase_p0    <= 2'd0;
      word_p0     <= '0;
      vld_p0      <= 1'b0;
      ramp_p0     <= '0;
      lfsr_p0     <= PRBS_SEED;
      alt_p0      <= 1'b0;
      slip_p0     <= 3'd0;
      undr_cnt_p0 <= 16'd0;
      fr_r        <= 1'b0;
      fr_f        <= 1'b0;
    end else begin
      if (!enb) begin
        phase_p0 <= 2'd0;
        vld_p0   <= 1'b0;
        alt_p0   <= 1'b0;
      end else begin
        phase_p0 <= (phase_p0 == 2'd2) ? 2'd0 : phase_p0 + 2'd1;
      end
      if (load) begin
        word_p0 <= next_word;
        vld_p0  <= 1'b1;
        slip_p0 <= slip_clamp(slip);
        if (mode_sel == MODE_RAMP) ramp_p0 <= ramp_p0 + 12'd1;
        if (mode_sel == MODE_ALT)  alt_p0  <= !alt_p0;
        if (mode_sel == MODE_PRBS) lfsr_p0 <= lfsr_next(lfsr_p0);
      end
      if (cnt_clr)       undr_cnt_p0 <= 16'd0;
      else if (underrun) undr_cnt_p0 <= sat_inc(undr_cnt_p0);
      {fr_r, fr_f} <= emit ? frame_pair : 2'b00;
    end
  end

  // ---- stage p1: per-channel serializers ----
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    adc_txemu_adc1xmt u_ch (
      .CLK      (CLK),
      .reset_n  (reset_n),
      .emit     (emit),
      .pair_sel (pair_sel),
      .word     (word_p0[k*NBITS +: NBITS]),
      .slip     (slip_p0),
      .dout_r   (dout_r[2*k +: 2]),
      .dout_f   (dout_f[2*k +: 2])
    );
  end

endmodule

// File: tb/tb_adc_txemu.sv
// Self-checking bench for adc_txemu: a frame-synchronised monitor rebuilds channel
// words from the serial pairs, and each test compares them with a behavioural model.
module tb_adc_txemu;
  localparam int NCH = 4;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        enb = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [11:0] pattern = 12'd0;
  logic [2:0]  slip = 3'd0;
  logic [47:0] din = '0;
  logic        din_valid = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        din_ready, fr_r, fr_f;
  logic [7:0]  dout_r, dout_f;
  logic [15:0] undr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] cap_q[$];
  bit          cap_en = 1'b0;

  always #5 CLK = ~CLK;

  adc_txemu #(.NCH(NCH), .PRBS_SEED(12'hFFF)) dut (
    .CLK(CLK), .reset_n(reset_n), .enb(enb), .mode(mode), .pattern(pattern),
    .slip(slip), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout_r(dout_r), .dout_f(dout_f), .fr_r(fr_r), .fr_f(fr_f),
    .undr_cnt(undr_cnt), .cnt_clr(cnt_clr)
  );

  // Monitor: collects each complete frame (pairs 11,10,00) into one 48-bit word.
  logic [7:0][5:0] lacc;
  int mpair = -1;
  always @(negedge CLK) begin
    logic [47:0] w;
    if (fr_r && fr_f)                             mpair = 0;
    else if (mpair == 0 && fr_r && !fr_f)         mpair = 1;
    else if (mpair == 1 && !fr_r && !fr_f)        mpair = 2;
    else                                          mpair = -1;
    if (mpair >= 0)
      for (int l = 0; l < 8; l++) lacc[l] = {lacc[l][3:0], dout_r[l], dout_f[l]};
    if (mpair == 2 && cap_en) begin
      for (int k = 0; k < NCH; k++) w[12*k +: 12] = {lacc[2*k+1], lacc[2*k]};
      cap_q.push_back(w);
    end
  end

  function automatic logic [11:0] prbs_step(input logic [11:0] s);
    return {s[10:0], ^(s & 12'hE08)};
  endfunction

  // Frame-aligned view of a periodic lane stream delayed by s bits.
  function automatic logic [5:0] slip_lane(input logic [5:0] lane, input int s);
    logic [5:0] o;
    for (int j = 0; j < 6; j++) o[5-j] = lane[5 - ((j - s + 6) % 6)];
    return o;
  endfunction

  task automatic apply_reset(input logic [3:0] m, input logic e);
    reset_n = 1'b0;
    mode = m;
    enb = e;
    repeat (2) @(negedge CLK);
    cap_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_words(input int n);
    repeat (3*n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge CLK);
      if (fr_r && fr_f) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL frame_sync: no frame start seen within 20 cycles");
    end
  endtask

  task automatic feed(input logic [47:0] w, input logic v, input logic clr);
    int t;
    t = 0;
    @(negedge CLK);
    while (!din_ready && t < 10) begin
      @(negedge CLK);
      t++;
    end
    n_tests++;
    if (!din_ready) begin
      n_fail++;
      $display("FAIL din_ready_wait: din_ready=%b required 1", din_ready);
    end
    din = w;
    din_valid = v;
    cnt_clr = clr;
    @(posedge CLK);
  endtask

  task automatic test_reset;
    pattern = 12'hFFF;
    mode = 4'd1;
    enb = 1'b1;
    @(negedge CLK);
    n_tests++;
    if ({dout_r, dout_f, fr_r, fr_f} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {dout_r, dout_f, fr_r, fr_f});
    end
    n_tests++;
    if (undr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_undr_cnt: got %h required 0", undr_cnt);
    end
    n_tests++;
    if (din_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_din_ready: got %b required 0", din_ready);
    end
  endtask

  task automatic check_pairs(input string nm, input logic [7:0] er[3], input logic [7:0] ef[3]);
    bit ok;
    logic [1:0] efr[3];
    efr = '{2'b11, 2'b10, 2'b00};
    sync_frame(ok);
    if (ok) begin
      for (int p = 0; p < 3; p++) begin
        if (p > 0) @(negedge CLK);
        n_tests++;
        if (dout_r !== er[p]) begin
          n_fail++; $display("FAIL %s_r%0d: got %h required %h", nm, p, dout_r, er[p]);
        end
        n_tests++;
        if (dout_f !== ef[p]) begin
          n_fail++; $display("FAIL %s_f%0d: got %h required %h", nm, p, dout_f, ef[p]);
        end
        n_tests++;
        if ({fr_r, fr_f} !== efr[p]) begin
          n_fail++; $display("FAIL %s_frame%0d: got %b required %b", nm, p, {fr_r, fr_f}, efr[p]);
        end
      end
    end
  endtask

  task automatic test_fixed_abc;
    logic [7:0] er[3];
    logic [7:0] ef[3];
    pattern = 12'hABC;
    slip = 3'd0;
    apply_reset(4'd1, 1'b1);
    wait_words(2);
    er = '{8'hFF, 8'hFF, 8'hAA};
    ef = '{8'h55, 8'h55, 8'h00};
    check_pairs("abc_slip0", er, ef);
    slip = 3'd1;
    wait_words(3);
    er = '{8'h00, 8'h55, 8'h55};
    ef = '{8'hFF, 8'hFF, 8'hAA};
    check_pairs("abc_slip1", er, ef);
  endtask

  task automatic test_fixed_random;
    logic [11:0] p;
    int s, se;
    logic [47:0] ew;
    for (int it = 0; it < 6; it++) begin
      p = 12'($urandom_range(0, 4095));
      s = (it == 0) ? 7 : $urandom_range(0, 7);
      se = (s > 5) ? 5 : s;
      pattern = p;
      slip = 3'(s);
      wait_words(3);
      cap_q.delete();
      cap_en = 1'b1;
      wait_words(3);
      cap_en = 1'b0;
      ew = {4{slip_lane(p[11:6], se), slip_lane(p[5:0], se)}};
      n_tests++;
      if (cap_q.size() < 2) begin
        n_fail++; $display("FAIL fixed_rand_count: got %0d words required >=2", cap_q.size());
      end else begin
        for (int i = 0; i < 2; i++) begin
          n_tests++;
          if (cap_q[i] !== ew) begin
            n_fail++;
            $display("FAIL fixed_rand p=%h slip=%0d: got %h required %h", p, s, cap_q[i], ew);
          end
        end
      end
    end
    slip = 3'd0;
  endtask

  task automatic test_ramp;
    logic [47:0] ew;
    cap_en = 1'b1;
    slip = 3'd0;
    apply_reset(4'd2, 1'b1);
    wait_words(8);
    cap_en = 1'b0;
    n_tests++;
    if (cap_q.size() < 6) begin
      n_fail++; $display("FAIL ramp_count: got %0d words required >=6", cap_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        for (int k = 0; k < NCH; k++) ew[12*k +: 12] = 12'((i + k) % 4096);
        n_tests++;
        if (cap_q[i] !== ew) begin
          n_fail++; $display("FAIL ramp_word%0d: got %h required %h", i, cap_q[i], ew);
        end
      end
    end
  endtask

  task automatic test_alt_deskew;
    logic [47:0] aaa, h555, fc0;
    aaa = {4{12'hAAA}};
    h555 = {4{12'h555}};
    fc0 = {4{12'hFC0}};
    cap_en = 1'b1;
    apply_reset(4'd3, 1'b0);
    enb = 1'b1;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    enb = 1'b0;
    repeat (4) @(negedge CLK);
    n_tests++;
    if (cap_q.size() != 2 || cap_q[0] !== aaa || cap_q[1] !== h555) begin
      n_fail++;
      $display("FAIL alt_first_run: got %0d words first %h required 2 words AAA then 555",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 48'd0);
    end
    cap_q.delete();
    enb = 1'b1;
    wait_words(4);
    n_tests++;
    if (cap_q.size() < 3) begin
      n_fail++; $display("FAIL alt_count: got %0d words required >=3", cap_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (cap_q[i] !== ((i % 2 == 0) ? aaa : h555)) begin
          n_fail++; $display("FAIL alt_word%0d: got %h required %h", i, cap_q[i],
                             (i % 2 == 0) ? aaa : h555);
        end
      end
    end
    mode = 4'd4;
    wait_words(2);
    cap_q.delete();
    wait_words(3);
    cap_en = 1'b0;
    n_tests++;
    if (cap_q.size() < 1 || cap_q[0] !== fc0) begin
      n_fail++; $display("FAIL deskew_word: got %h required %h",
                         (cap_q.size() > 0) ? cap_q[0] : 48'd0, fc0);
    end
  endtask

  task automatic test_prbs;
    logic [11:0] s;
    logic [47:0] seed_w;
    seed_w = {4{12'hFFF}};
    cap_en = 1'b1;
    apply_reset(4'd5, 1'b1);
    wait_words(4098);
    cap_en = 1'b0;
    n_tests++;
    if (cap_q.size() < 4096) begin
      n_fail++; $display("FAIL prbs_count: got %0d words required >=4096", cap_q.size());
    end else begin
      s = 12'hFFF;
      for (int i = 0; i < 4096; i++) begin
        n_tests++;
        if (cap_q[i] !== {4{s}}) begin
          n_fail++; $display("FAIL prbs_word%0d: got %h required %h", i, cap_q[i], {4{s}});
          break;
        end
        s = prbs_step(s);
      end
      n_tests++;
      if (cap_q[4095] !== seed_w) begin
        n_fail++; $display("FAIL prbs_period: word4095 got %h required %h", cap_q[4095], seed_w);
      end
    end
  endtask

  task automatic test_underrun;
    logic [47:0] w0, w1, w2;
    logic [47:0] exp_w[5];
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    exp_w = '{w0, w1, w1, w1, w2};
    din = w0;
    din_valid = 1'b1;
    cap_en = 1'b1;
    apply_reset(4'd0, 1'b1);
    feed(w1, 1'b1, 1'b0);
    feed(48'd0, 1'b0, 1'b0);
    feed(48'd0, 1'b0, 1'b0);
    feed(w2, 1'b1, 1'b0);
    wait_words(3);
    cap_en = 1'b0;
    n_tests++;
    if (cap_q.size() < 5) begin
      n_fail++; $display("FAIL underrun_count_words: got %0d required >=5", cap_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (cap_q[i] !== exp_w[i]) begin
          n_fail++; $display("FAIL underrun_word%0d: got %h required %h", i, cap_q[i], exp_w[i]);
        end
      end
    end
    n_tests++;
    if (undr_cnt !== 16'd2) begin
      n_fail++; $display("FAIL undr_cnt_two: got %0d required 2", undr_cnt);
    end
    feed(48'd0, 1'b0, 1'b1);
    @(negedge CLK);
    din_valid = 1'b1;
    cnt_clr = 1'b0;
    n_tests++;
    if (undr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL undr_cnt_clr_wins: got %0d required 0", undr_cnt);
    end
    feed(48'd0, 1'b0, 1'b0);
    @(negedge CLK);
    din_valid = 1'b1;
    n_tests++;
    if (undr_cnt !== 16'd1) begin
      n_fail++; $display("FAIL undr_cnt_after_clr: got %0d required 1", undr_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] exp_q[$];
    logic [47:0] last, w;
    logic v;
    int undr;
    last = {$urandom, $urandom};
    din = last;
    din_valid = 1'b1;
    exp_q.push_back(last);
    undr = 0;
    cap_en = 1'b1;
    apply_reset(4'd0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      v = ($urandom_range(0, 3) != 0);
      w = {$urandom, $urandom};
      feed(w, v, 1'b0);
      if (v) last = w;
      else undr++;
      exp_q.push_back(last);
    end
    @(negedge CLK);
    din_valid = 1'b1;
    wait_words(3);
    cap_en = 1'b0;
    n_tests++;
    if (cap_q.size() < exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d words required >=%0d", cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (cap_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL b2b_word%0d: got %h required %h", i, cap_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (undr_cnt !== 16'(undr)) begin
      n_fail++; $display("FAIL b2b_undr_cnt: got %0d required %0d", undr_cnt, undr);
    end
  endtask

  task automatic test_async_restart;
    logic [11:0] p;
    bit ok;
    p = 12'($urandom_range(0, 4095));
    pattern = p;
    slip = 3'd0;
    apply_reset(4'd1, 1'b1);
    wait_words(2);
    sync_frame(ok);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({dout_r, dout_f, fr_r, fr_f} !== 18'd0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h required 0", {dout_r, dout_f, fr_r, fr_f});
    end
    @(negedge CLK);
    reset_n = 1'b1;
    wait_words(2);
    sync_frame(ok);
    enb = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({dout_r, dout_f, fr_r, fr_f} !== 18'd0) begin
      n_fail++; $display("FAIL enb_low_outputs: got %h required 0", {dout_r, dout_f, fr_r, fr_f});
    end
    enb = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    n_tests++;
    if ({fr_r, fr_f} !== 2'b11) begin
      n_fail++; $display("FAIL restart_frame: got %b required 11", {fr_r, fr_f});
    end
    n_tests++;
    if (dout_r !== {4{p[11], p[5]}} || dout_f !== {4{p[10], p[4]}}) begin
      n_fail++; $display("FAIL restart_pair0: got r=%h f=%h required r=%h f=%h",
                         dout_r, dout_f, {4{p[11], p[5]}}, {4{p[10], p[4]}});
    end
  endtask

  initial begin
    test_reset();
    test_fixed_abc();
    test_fixed_random();
    test_ramp();
    test_alt_deskew();
    test_prbs();
    test_underrun();
    test_back_to_back();
    test_async_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
